// File: rtl/cpu_io_pkg.sv
// Shared definitions for the memory-mapped I/O and interrupt controller.
// Holds the I/O word offsets, which are counted down from the top word
// address, the STATUS register bit positions and the read-select encoding.
package cpu_io_pkg;

    // Word offsets below the top (all-ones) word address
    localparam int unsigned OFF_OUT     = 0;
    localparam int unsigned OFF_IN      = 1;
    localparam int unsigned OFF_STATUS  = 2;
    localparam int unsigned OFF_MASK    = 3;
    localparam int unsigned OFF_CAPTURE = 4;

    // STATUS register bit positions
    localparam int unsigned ST_PENDING  = 0;
    localparam int unsigned ST_OVERFLOW = 1;

    // Read/write target selected by the address decoder
    typedef enum logic [2:0] {
        IO_RAM     = 3'd0,
        IO_OUT     = 3'd1,
        IO_IN      = 3'd2,
        IO_STATUS  = 3'd3,
        IO_MASK    = 3'd4,
        IO_CAPTURE = 3'd5
    } io_sel_e;

    // Interrupt handshake state
    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PENDING = 1'b1
    } irq_state_e;

endpackage

// File: rtl/in_sync_change.sv
// Input synchronizer and change detector for the asynchronous board pins.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   entrada_i      - asynchronous board input
//   in_sync_o      - synchronized input (last stage of the flop chain)
//   change_c       - combinational: synchronized input differs from the
//                    previous cycle's value, gated until warm-up completes
module in_sync_change
    import cpu_io_pkg::*;
#(
    parameter int unsigned NBITS       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] entrada_i,
    output logic [NBITS-1:0] in_sync_o,
    output logic             change_c
);

    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned CW       = $clog2(WARM_MAX + 1);

    logic [NBITS-1:0] sync_q [SYNC_STAGES];
    logic [NBITS-1:0] prev_q;
    logic [CW-1:0]    warm_q;
    logic [CW-1:0]    warm_d;
    logic             armed;

    // Warm-up counter saturates once the chain has flushed post-reset zeros
    always_comb begin
        warm_d = warm_q;
        if (warm_q != CW'(WARM_MAX)) begin
            warm_d = warm_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= entrada_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            warm_q <= warm_d;
        end
    end

    assign armed     = (warm_q == CW'(WARM_MAX));
    assign in_sync_o = sync_q[SYNC_STAGES-1];
    assign change_c  = armed && (sync_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/io_irq_controller.sv
// Memory-mapped I/O and interrupt controller sitting between the processor
// data port, the synchronous RAM and the board pins.
// Ports:
//   clock, reset     - clock and synchronous active-high reset
//   mem_address      - processor word address
//   mem_write_data   - processor write data
//   mem_write        - processor write strobe
//   mem_read_data    - read data to processor (1-cycle latency, like the RAM)
//   ram_read_data    - RAM q output
//   ram_wren         - RAM write enable (combinational, never for I/O words)
//   entrada          - asynchronous board input
//   saida            - board output register
//   interrupt        - interrupt request (pending && mask, from registers)
module io_irq_controller
    import cpu_io_pkg::*;
#(
    parameter int unsigned NBITS       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-3:0] mem_address,
    input  logic [NBITS-1:0] mem_write_data,
    input  logic             mem_write,
    output logic [NBITS-1:0] mem_read_data,
    input  logic [NBITS-1:0] ram_read_data,
    output logic             ram_wren,
    input  logic [NBITS-1:0] entrada,
    output logic [NBITS-1:0] saida,
    output logic             interrupt
);

    localparam int unsigned AW = NBITS - 2;

    localparam logic [AW-1:0] ADDR_TOP     = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_OUT     = ADDR_TOP - AW'(OFF_OUT);
    localparam logic [AW-1:0] ADDR_IN      = ADDR_TOP - AW'(OFF_IN);
    localparam logic [AW-1:0] ADDR_STATUS  = ADDR_TOP - AW'(OFF_STATUS);
    localparam logic [AW-1:0] ADDR_MASK    = ADDR_TOP - AW'(OFF_MASK);
    localparam logic [AW-1:0] ADDR_CAPTURE = ADDR_TOP - AW'(OFF_CAPTURE);

    logic [NBITS-1:0] in_sync;
    logic             change;

    io_sel_e          sel_c;
    logic             clr_pend;
    logic             clr_ovf;

    irq_state_e       state_q,   state_d;
    logic             overflow_q, overflow_d;
    logic             mask_q,    mask_d;
    logic [NBITS-1:0] capture_q, capture_d;
    logic [NBITS-1:0] saida_q,   saida_d;
    logic             io_sel_q,  io_sel_d;
    logic [NBITS-1:0] rdata_q,   rdata_d;

    in_sync_change #(
        .NBITS       (NBITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync_change (
        .clock     (clock),
        .reset     (reset),
        .entrada_i (entrada),
        .in_sync_o (in_sync),
        .change_c  (change)
    );

    // Address decode
    always_comb begin
        sel_c = IO_RAM;
        if (mem_address == ADDR_OUT) begin
            sel_c = IO_OUT;
        end else if (mem_address == ADDR_IN) begin
            sel_c = IO_IN;
        end else if (mem_address == ADDR_STATUS) begin
            sel_c = IO_STATUS;
        end else if (mem_address == ADDR_MASK) begin
            sel_c = IO_MASK;
        end else if (mem_address == ADDR_CAPTURE) begin
            sel_c = IO_CAPTURE;
        end
    end

    assign ram_wren = mem_write && (sel_c == IO_RAM);
    assign clr_pend = mem_write && (sel_c == IO_STATUS) && mem_write_data[ST_PENDING];
    assign clr_ovf  = mem_write && (sel_c == IO_STATUS) && mem_write_data[ST_OVERFLOW];

    // Next-state: writable registers, interrupt handshake and read capture
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        mask_d     = mask_q;
        capture_d  = capture_q;
        saida_d    = saida_q;
        io_sel_d   = (sel_c != IO_RAM);
        rdata_d    = '0;

        if (mem_write && (sel_c == IO_OUT)) begin
            saida_d = mem_write_data;
        end
        if (mem_write && (sel_c == IO_MASK)) begin
            mask_d = mem_write_data[0];
        end
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        // A change always wins over a coincident clear
        case (state_q)
            IRQ_IDLE: begin
                if (change) begin
                    state_d   = IRQ_PENDING;
                    capture_d = in_sync;
                end
            end
            IRQ_PENDING: begin
                if (change && clr_pend) begin
                    capture_d = in_sync;
                end else if (change) begin
                    overflow_d = 1'b1;
                end else if (clr_pend) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase

        // Read value sampled from current registers, so same-cycle writes
        // are not visible until the following read
        case (sel_c)
            IO_OUT:     rdata_d = saida_q;
            IO_IN:      rdata_d = in_sync;
            IO_STATUS: begin
                rdata_d[ST_PENDING]  = (state_q == IRQ_PENDING);
                rdata_d[ST_OVERFLOW] = overflow_q;
            end
            IO_MASK:    rdata_d[0] = mask_q;
            IO_CAPTURE: rdata_d = capture_q;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IRQ_IDLE;
            overflow_q <= 1'b0;
            mask_q     <= 1'b0;
            capture_q  <= '0;
            saida_q    <= '0;
            io_sel_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            mask_q     <= mask_d;
            capture_q  <= capture_d;
            saida_q    <= saida_d;
            io_sel_q   <= io_sel_d;
            rdata_q    <= rdata_d;
        end
    end

    assign saida         = saida_q;
    assign interrupt     = (state_q == IRQ_PENDING) && mask_q;
    assign mem_read_data = io_sel_q ? rdata_q : ram_read_data;

endmodule

// File: tb/tb_io_irq_controller.sv
// Directed self-checking bench for io_irq_controller (NBITS=8, SYNC_STAGES=2).
module tb_io_irq_controller;

    localparam logic [7:0] RAM_Q = 8'hEE;

    localparam logic [5:0] A_OUT     = 6'd63;
    localparam logic [5:0] A_IN      = 6'd62;
    localparam logic [5:0] A_STATUS  = 6'd61;
    localparam logic [5:0] A_MASK    = 6'd60;
    localparam logic [5:0] A_CAPTURE = 6'd59;

    logic       clock;
    logic       reset;
    logic [5:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write;
    logic [7:0] mem_read_data;
    logic [7:0] ram_read_data;
    logic       ram_wren;
    logic [7:0] entrada;
    logic [7:0] saida;
    logic       interrupt;

    int n_cmp;
    int n_bad;

    io_irq_controller #(
        .NBITS       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .ram_read_data  (ram_read_data),
        .ram_wren       (ram_wren),
        .entrada        (entrada),
        .saida          (saida),
        .interrupt      (interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and checks happen 1 time unit after it
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        mem_address    = a;
        mem_write_data = d;
        mem_write      = 1'b1;
        cycle();
        mem_write      = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
        mem_address = a;
        mem_write   = 1'b0;
        cycle();
        check_val(tag, 32'(mem_read_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        mem_address    = 6'd0;
        mem_write_data = 8'h00;
        mem_write      = 1'b0;
        ram_read_data  = RAM_Q;
        entrada        = 8'hA5;

        repeat (3) cycle();
        check_val("rst_irq",   32'(interrupt), 32'd0);
        check_val("rst_saida", 32'(saida), 32'h00);
        check_val("rst_rdata", 32'(mem_read_data), 32'(RAM_Q));

        // Post-reset warm-up with A5 held must not raise an event
        reset = 1'b0;
        repeat (10) cycle();
        check_val("warm_irq", 32'(interrupt), 32'd0);
        rd("warm_status", A_STATUS, 8'h00);
        rd("in_a5", A_IN, 8'hA5);

        // OUT write and RAM write steering
        mem_address = A_OUT; mem_write_data = 8'h3C; mem_write = 1'b1;
        #1 check_val("wren_out", 32'(ram_wren), 32'd0);
        cycle();
        mem_write = 1'b0;
        check_val("saida_3c", 32'(saida), 32'h3C);
        mem_address = 6'd5; mem_write_data = 8'h11; mem_write = 1'b1;
        #1 check_val("wren_ram", 32'(ram_wren), 32'd1);
        cycle();
        mem_write = 1'b0;
        check_val("saida_keep", 32'(saida), 32'h3C);
        check_val("ram_rdata", 32'(mem_read_data), 32'(RAM_Q));

        // Bring input to 00 unmasked, then clear whatever got latched
        entrada = 8'h00;
        repeat (4) cycle();
        wr(A_STATUS, 8'h03);
        rd("st_clean", A_STATUS, 8'h00);

        // Masked-in event: 3-edge latency
        wr(A_MASK, 8'h01);
        entrada = 8'h07;
        cycle();
        check_val("lat_e0", 32'(interrupt), 32'd0);
        cycle();
        check_val("lat_e1", 32'(interrupt), 32'd0);
        cycle();
        check_val("lat_e2", 32'(interrupt), 32'd1);
        rd("cap_07", A_CAPTURE, 8'h07);

        // Second change while pending -> overflow, capture held
        entrada = 8'h0F;
        repeat (4) cycle();
        rd("st_ovf", A_STATUS, 8'h03);
        rd("cap_hold", A_CAPTURE, 8'h07);
        wr(A_STATUS, 8'h02);
        rd("st_ovf_clr", A_STATUS, 8'h01);
        check_val("irq_still", 32'(interrupt), 32'd1);
        wr(A_STATUS, 8'h01);
        check_val("irq_clr", 32'(interrupt), 32'd0);
        rd("st_idle", A_STATUS, 8'h00);

        // Event while masked survives until mask is enabled
        wr(A_MASK, 8'h00);
        entrada = 8'h1E;
        repeat (4) cycle();
        check_val("masked_irq", 32'(interrupt), 32'd0);
        rd("masked_st", A_STATUS, 8'h01);
        wr(A_MASK, 8'h01);
        check_val("unmask_irq", 32'(interrupt), 32'd1);
        rd("mask_rd", A_MASK, 8'h01);
        rd("out_rd", A_OUT, 8'h3C);

        // Clear coincident with a change: set wins, capture updates
        entrada = 8'h2D;
        cycle();
        cycle();
        wr(A_STATUS, 8'h01);
        check_val("coinc_irq", 32'(interrupt), 32'd1);
        rd("coinc_cap", A_CAPTURE, 8'h2D);
        rd("coinc_st", A_STATUS, 8'h01);

        // Writes to IN are ignored and never reach RAM
        mem_address = A_IN; mem_write_data = 8'hFF; mem_write = 1'b1;
        #1 check_val("wren_in", 32'(ram_wren), 32'd0);
        cycle();
        mem_write = 1'b0;
        rd("in_ro", A_IN, 8'h2D);

        // Same-cycle read/write of OUT returns pre-write value
        mem_address = A_OUT; mem_write_data = 8'h55; mem_write = 1'b1;
        cycle();
        mem_write = 1'b0;
        check_val("rw_pre", 32'(mem_read_data), 32'h3C);
        check_val("rw_saida", 32'(saida), 32'h55);

        // Reset while interrupt is up
        check_val("pre_rst_irq", 32'(interrupt), 32'd1);
        reset = 1'b1;
        cycle();
        check_val("mrst_irq", 32'(interrupt), 32'd0);
        check_val("mrst_saida", 32'(saida), 32'h00);
        check_val("mrst_rdata", 32'(mem_read_data), 32'(RAM_Q));
        reset = 1'b0;

        // Unmask immediately; synchronizer ramp-up must not trigger
        wr(A_MASK, 8'h01);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("warm2_irq%0d", i), 32'(interrupt), 32'd0);
            cycle();
        end
        rd("warm2_st", A_STATUS, 8'h00);
        rd("warm2_in", A_IN, 8'h2D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
